// File: rtl/simd4_unpack.sv
// Unpacks a 48-bit word of four 12-bit lanes into one OUT_W-bit lane per transfer.
// Define SIMD4_UNPACK_SEXT_EN for sign extension of each lane; otherwise lanes are zero-extended.
//
// state   | meaning
// S_EMPTY | no word held, ready to accept a packed word
// S_BUSY  | word held, r_lane selects the lane being offered
module simd4_unpack #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_last
);

    typedef enum logic {S_EMPTY = 1'b0, S_BUSY = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_lane;
    logic [1:0]        w_lane_nxt;
    logic [47:0]       r_hold;
    logic [47:0]       w_hold_nxt;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [11:0]       w_lane_bits;
    logic [OUT_W-1:0]  w_ext;

    assign w_in_xfer  = in_valid & in_ready & ce;
    assign w_out_xfer = out_valid & out_ready & ce;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_lane  <= 2'd0;
            r_hold  <= 48'd0;
        end else if (ce) begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Lane 3 can hand over directly to a freshly loaded word, avoiding an idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = S_BUSY;
                    w_lane_nxt  = 2'd0;
                    w_hold_nxt  = in_data;
                end
            end
            S_BUSY: begin
                if (w_out_xfer) begin
                    if (r_lane != 2'd3) begin
                        w_lane_nxt = r_lane + 2'd1;
                    end else if (w_in_xfer) begin
                        w_lane_nxt = 2'd0;
                        w_hold_nxt = in_data;
                    end else begin
                        w_state_nxt = S_EMPTY;
                        w_lane_nxt  = 2'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_lane_bits = r_hold[47:36];
            2'd1:    w_lane_bits = r_hold[35:24];
            2'd2:    w_lane_bits = r_hold[23:12];
            default: w_lane_bits = r_hold[11:0];
        endcase
    end

`ifdef SIMD4_UNPACK_SEXT_EN
    assign w_ext = OUT_W'($signed(w_lane_bits));
`else
    assign w_ext = OUT_W'(w_lane_bits);
`endif

    // Outputs are forced quiet while reset is asserted, whatever the held state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_lane  = 2'd0;
        out_last  = 1'b0;
        if (rst) begin
            case (r_state)
                S_EMPTY: begin
                    in_ready = ce;
                end
                S_BUSY: begin
                    out_valid = 1'b1;
                    out_data  = w_ext;
                    out_lane  = r_lane;
                    out_last  = (r_lane == 2'd3);
                    in_ready  = (r_lane == 2'd3) & out_ready & ce;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd4_unpack.sv
// Bench for simd4_unpack: directed scenarios then random traffic against a lane-queue model.
// Expected lane extension follows SIMD4_UNPACK_SEXT_EN, matching the build under test.
module tb_simd4_unpack;

    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             in_valid;
    logic             in_ready;
    logic [47:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_lane;
    logic             out_last;

    int checks   = 0;
    int failures = 0;
    int ov_seen  = 0;

    logic [OUT_W-1:0] q[$];

    simd4_unpack #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] ext12(input logic [11:0] l);
        int s;
        s = int'(l);
`ifdef SIMD4_UNPACK_SEXT_EN
        if (s >= 2048) s = s - 4096;
`endif
        return OUT_W'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model, cross the edge.
    task automatic cyc(input logic v, input logic [47:0] d, input logic ordy,
                       input logic ce_i, input logic rst_i);
        logic             e_valid;
        logic             e_rdy;
        logic             e_last;
        logic [1:0]       e_lane;
        logic [OUT_W-1:0] e_data;
        int               n;
        rst       = rst_i;
        ce        = ce_i;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        n       = q.size();
        e_valid = rst_i && (n > 0);
        e_lane  = e_valid ? 2'(4 - n) : 2'd0;
        e_data  = e_valid ? q[0] : '0;
        e_last  = e_valid && (n == 1);
        e_rdy   = rst_i && ce_i && ((n == 0) || ((n == 1) && ordy));
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("out_data", 64'(out_data), 64'(e_data));
        chk("out_lane", 64'(out_lane), 64'(e_lane));
        chk("out_last", 64'(out_last), 64'(e_last));
        if (out_valid === 1'b1) ov_seen++;
        if (!rst_i) begin
            q.delete();
        end else if (ce_i) begin
            if (e_valid && ordy) void'(q.pop_front());
            if (v && e_rdy) begin
                q.push_back(ext12(d[47:36]));
                q.push_back(ext12(d[35:24]));
                q.push_back(ext12(d[23:12]));
                q.push_back(ext12(d[11:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [47:0] w_basic;
        logic [15:0] exp_l2;
        logic [15:0] exp_l3;
        w_basic = 48'h001_7FF_800_FFF;
`ifdef SIMD4_UNPACK_SEXT_EN
        exp_l2 = 16'hF800;
        exp_l3 = 16'hFFFF;
`else
        exp_l2 = 16'h0800;
        exp_l3 = 16'h0FFF;
`endif
        rst = 1'b0; ce = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset, including with ce low
        cyc(1'b0, 48'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 48'hABC_DEF_123_456, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 48'd0, 1'b0, 1'b1, 1'b1);

        // basic unpack
        cyc(1'b1, w_basic, 1'b1, 1'b1, 1'b1);
        chk("basic_l0_data", 64'(out_data), 64'h0001);
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);
        chk("basic_l1_data", 64'(out_data), 64'h07FF);
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);
        chk("basic_l2_data", 64'(out_data), 64'(exp_l2));
        chk("basic_l2_last", 64'(out_last), 64'd0);
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);
        chk("basic_l3_data", 64'(out_data), 64'(exp_l3));
        chk("basic_l3_last", 64'(out_last), 64'd1);
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);

        // back-to-back words
        ov_seen = 0;
        cyc(1'b1, 48'h123_456_789_ABC, 1'b1, 1'b1, 1'b1);
        repeat (4) cyc(1'b1, 48'hFED_CBA_987_654, 1'b1, 1'b1, 1'b1);
        repeat (5) cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);
        chk("b2b_valid_cycles", 64'(ov_seen), 64'd8);

        // backpressure at lane 1
        cyc(1'b1, 48'h800_7FF_001_FFF, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 48'h111_222_333_444, 1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 48'h111_222_333_444, 1'b0, 1'b1, 1'b1);
        chk("bp_lane_held", 64'(out_lane), 64'd1);
        repeat (4) cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);

        // ce freeze at lane 2
        cyc(1'b1, 48'hA5A_5A5_F0F_0F0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 48'h222_333_444_555, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc(1'b1, 48'h222_333_444_555, 1'b1, 1'b0, 1'b1);
        chk("ce_lane_held", 64'(out_lane), 64'd2);
        repeat (3) cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);

        // reset mid-word at lane 1
        cyc(1'b1, 48'h0F0_F0F_FFF_000, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 48'h333_444_555_666, 1'b1, 1'b1, 1'b0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        cyc(1'b1, 48'h9AB_CDE_F01_234, 1'b1, 1'b1, 1'b1);
        chk("rst_next_lane0", 64'(out_lane), 64'd0);
        repeat (4) cyc(1'b0, 48'd0, 1'b1, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom_range(0, 1)),
                {16'($urandom), 32'($urandom)},
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 49) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
